// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-port 1024x32 data memory.
//   master : requester side (CPU LSU on port 0, DMA/debug loader on port 1)
//   slave  : arbiter side
//   mem    : memory side
interface dmem_port_arbiter_if;
   logic        p0_req;
   logic        p0_we;
   logic [31:0] p0_addr;
   logic [31:0] p0_wdata;
   logic        p0_gnt;
   logic        p0_rvalid;
   logic [31:0] p0_rdata;
   logic        p0_err;

   logic        p1_req;
   logic        p1_we;
   logic [31:0] p1_addr;
   logic [31:0] p1_wdata;
   logic        p1_gnt;
   logic        p1_rvalid;
   logic [31:0] p1_rdata;
   logic        p1_err;

   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic        mem_wen;
   logic        mem_ren;
   logic [31:0] mem_dout;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata, p1_err
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_gnt, p0_rvalid, p0_rdata, p0_err,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata, p1_err,
      output mem_addr, mem_din, mem_wen, mem_ren,
      input  mem_dout
   );

   modport mem (
      input  mem_addr, mem_din, mem_wen, mem_ren,
      output mem_dout
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port 1024x32 data memory.
// One access per cycle; byte address -> word index; illegal (misaligned or
// beyond 4 KiB) accesses take the slot but are answered with an err pulse.
// Read data comes back one cycle after the grant, steered by an owner tag.
//
// Build option: DMEM_ARB_RR_EN
//   undefined : contested cycles go to port 0 until MAX_STREAK consecutive
//               contested wins, then port 1 gets one.
//   defined   : contested cycles alternate on the last granted port
//               (resets to port 1, so port 0 wins the first contest).
//
// Arbitration state:
//   state             | meaning
//   r_streak (fixed)  | consecutive port 0 grants while port 1 was waiting
//   r_last_p1 (rr)    | 1 = most recent grant went to port 1
module dmem_port_arbiter #(
   parameter int MAX_STREAK = 4
) (
   input logic               clk,
   input logic               reset,
   dmem_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(MAX_STREAK + 1);

   logic        w_req0;
   logic        w_req1;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_any_gnt;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic        w_sel_legal;
   logic        w_mem_wen;
   logic        w_mem_ren;
   logic [9:0]  w_mem_addr;
   logic [31:0] w_mem_din;

   logic        r_rvalid0;
   logic        r_rvalid1;
   logic        r_err0;
   logic        r_err1;

`ifdef DMEM_ARB_RR_EN
   logic        r_last_p1;
   logic        w_last_p1_nxt;
`else
   logic [SW-1:0] r_streak;
   logic [SW-1:0] w_streak_nxt;
`endif

   // Requests are ignored while reset is asserted so nothing is granted.
   assign w_req0 = bus.p0_req & ~reset;
   assign w_req1 = bus.p1_req & ~reset;

   // Winner selection: single requester wins outright, contention uses the
   // configured policy.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_req0 && w_req1) begin
`ifdef DMEM_ARB_RR_EN
         w_gnt0 = r_last_p1;
`else
         w_gnt0 = (r_streak != SW'(MAX_STREAK));
`endif
         w_gnt1 = ~w_gnt0;
      end else begin
         w_gnt0 = w_req0;
         w_gnt1 = w_req1;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // State register: last granted port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_last_p1 <= 1'b1;
      else       r_last_p1 <= w_last_p1_nxt;
   end

   // Next state: remember whichever port was granted, hold on idle cycles.
   always_comb begin
      w_last_p1_nxt = r_last_p1;
      if (w_gnt1)      w_last_p1_nxt = 1'b1;
      else if (w_gnt0) w_last_p1_nxt = 1'b0;
   end
`else
   // State register: port 0 streak counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_streak <= '0;
      else       r_streak <= w_streak_nxt;
   end

   // Next state: count port 0 wins while port 1 waits; any cycle without a
   // port 0 grant restarts the streak. Port 0 alone holds the count.
   always_comb begin
      w_streak_nxt = r_streak;
      if (w_gnt1 || !w_gnt0)
         w_streak_nxt = '0;
      else if (w_req1 && (r_streak != SW'(MAX_STREAK)))
         w_streak_nxt = r_streak + SW'(1);
   end
`endif

   // Output decode: mux the winner onto the memory and derive enables.
   always_comb begin
      w_any_gnt   = w_gnt0 | w_gnt1;
      w_sel_we    = w_gnt1 ? bus.p1_we    : bus.p0_we;
      w_sel_addr  = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
      w_sel_wdata = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;
      w_sel_legal = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr[31:12] == 20'd0);
      w_mem_wen   = w_any_gnt & w_sel_legal & w_sel_we;
      w_mem_ren   = w_any_gnt & w_sel_legal & ~w_sel_we;
      w_mem_addr  = w_any_gnt ? w_sel_addr[11:2] : 10'd0;
      w_mem_din   = w_any_gnt ? w_sel_wdata : 32'd0;
   end

   // Response tags: which port owns next cycle's read data or error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_err0    <= 1'b0;
         r_err1    <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt0 & w_mem_ren;
         r_rvalid1 <= w_gnt1 & w_mem_ren;
         r_err0    <= w_gnt0 & ~w_sel_legal;
         r_err1    <= w_gnt1 & ~w_sel_legal;
      end
   end

   assign bus.p0_gnt    = w_gnt0;
   assign bus.p1_gnt    = w_gnt1;
   assign bus.p0_rvalid = r_rvalid0;
   assign bus.p1_rvalid = r_rvalid1;
   assign bus.p0_err    = r_err0;
   assign bus.p1_err    = r_err1;
   // Both ports see the memory output; rvalid tells the owner it is theirs.
   assign bus.p0_rdata  = reset ? 32'd0 : bus.mem_dout;
   assign bus.p1_rdata  = reset ? 32'd0 : bus.mem_dout;
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_din   = w_mem_din;
   assign bus.mem_wen   = w_mem_wen;
   assign bus.mem_ren   = w_mem_ren;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   dmem_port_arbiter_if bus ();

   dmem_port_arbiter #(.MAX_STREAK(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural data memory: registered read, write on the same edge,
   // cleared by reset.
   logic [31:0] mem [1024];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
         bus.mem_dout <= 32'd0;
      end else begin
         if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_din;
         if (bus.mem_ren) bus.mem_dout <= mem[bus.mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
   endtask

   task automatic drv0(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
   endtask

   task automatic drv1(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
   endtask

   initial begin
      logic exp1;
      logic prev1;
      prev1 = 1'b0;
      reset = 1'b1;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'd0; bus.p1_wdata = 32'd0;
      drv0(1'b0, 32'h0, 32'h0);

      // Reset: request present but nothing granted, all outputs low.
      smp();
      chk("rst_p0_gnt",    {31'd0, bus.p0_gnt},    32'd0);
      chk("rst_mem_ren",   {31'd0, bus.mem_ren},   32'd0);
      chk("rst_mem_wen",   {31'd0, bus.mem_wen},   32'd0);
      chk("rst_p0_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
      chk("rst_p1_err",    {31'd0, bus.p1_err},    32'd0);
      chk("rst_mem_addr",  {22'd0, bus.mem_addr},  32'd0);
      next_cyc();
      idle();
      reset = 1'b0;
      next_cyc();

      // Contention with both ports holding reads.
      drv0(1'b0, 32'h20, 32'h0);
      drv1(1'b0, 32'h24, 32'h0);
      for (int i = 0; i < 10; i++) begin
         smp();
`ifdef DMEM_ARB_RR_EN
         exp1 = (i % 2) == 1;
`else
         exp1 = (i % 5) == 4;
`endif
         chk($sformatf("cont_gnt1_%0d", i), {31'd0, bus.p1_gnt}, {31'd0, exp1});
         chk($sformatf("cont_gnt0_%0d", i), {31'd0, bus.p0_gnt}, {31'd0, ~exp1});
         if (i > 0) begin
            chk($sformatf("cont_rv1_%0d", i), {31'd0, bus.p1_rvalid}, {31'd0, prev1});
            chk($sformatf("cont_rv0_%0d", i), {31'd0, bus.p0_rvalid}, {31'd0, ~prev1});
         end
         prev1 = exp1;
         next_cyc();
      end
      idle();
      next_cyc();

      // Write then read back on port 0.
      drv0(1'b1, 32'h10, 32'hDEADBEEF);
      smp();
      chk("t1_wr_gnt",  {31'd0, bus.p0_gnt},  32'd1);
      chk("t1_wr_addr", {22'd0, bus.mem_addr}, 32'd4);
      chk("t1_wr_wen",  {31'd0, bus.mem_wen}, 32'd1);
      chk("t1_wr_ren",  {31'd0, bus.mem_ren}, 32'd0);
      chk("t1_wr_din",  bus.mem_din, 32'hDEADBEEF);
      next_cyc();
      drv0(1'b0, 32'h10, 32'h0);
      smp();
      chk("t1_rd_gnt",   {31'd0, bus.p0_gnt},    32'd1);
      chk("t1_rd_ren",   {31'd0, bus.mem_ren},   32'd1);
      chk("t1_wr_norv",  {31'd0, bus.p0_rvalid}, 32'd0);
      chk("t1_wr_noerr", {31'd0, bus.p0_err},    32'd0);
      next_cyc();
      idle();
      smp();
      chk("t1_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
      chk("t1_rdata",  bus.p0_rdata, 32'hDEADBEEF);
      chk("t1_p1_rv",  {31'd0, bus.p1_rvalid}, 32'd0);
      next_cyc();

      // Highest legal word address.
      drv1(1'b0, 32'hFFC, 32'h0);
      smp();
      chk("top_addr", {22'd0, bus.mem_addr}, 32'h3FF);
      chk("top_ren",  {31'd0, bus.mem_ren},  32'd1);
      next_cyc();
      idle();
      smp();
      chk("top_rv1",  {31'd0, bus.p1_rvalid}, 32'd1);
      chk("top_err1", {31'd0, bus.p1_err},    32'd0);
      next_cyc();

      // Misaligned read on port 1.
      drv1(1'b0, 32'h13, 32'h0);
      smp();
      chk("t3_gnt1", {31'd0, bus.p1_gnt},  32'd1);
      chk("t3_ren",  {31'd0, bus.mem_ren}, 32'd0);
      chk("t3_wen",  {31'd0, bus.mem_wen}, 32'd0);
      next_cyc();
      idle();
      smp();
      chk("t3_err1", {31'd0, bus.p1_err},    32'd1);
      chk("t3_rv1",  {31'd0, bus.p1_rvalid}, 32'd0);
      chk("t3_err0", {31'd0, bus.p0_err},    32'd0);
      next_cyc();
      smp();
      chk("t3_err1_pulse", {31'd0, bus.p1_err}, 32'd0);
      next_cyc();

      // Out-of-range write on port 0; word 0 must stay zero.
      drv0(1'b1, 32'h1000, 32'h12345678);
      smp();
      chk("t4_gnt0", {31'd0, bus.p0_gnt},  32'd1);
      chk("t4_wen",  {31'd0, bus.mem_wen}, 32'd0);
      next_cyc();
      drv0(1'b0, 32'h0, 32'h0);
      smp();
      chk("t4_err0", {31'd0, bus.p0_err},    32'd1);
      chk("t4_rv0",  {31'd0, bus.p0_rvalid}, 32'd0);
      next_cyc();
      idle();
      smp();
      chk("t4_rd_rv",   {31'd0, bus.p0_rvalid}, 32'd1);
      chk("t4_rd_data", bus.p0_rdata, 32'd0);
      chk("t4_noerr",   {31'd0, bus.p0_err}, 32'd0);
      next_cyc();

      // Back-to-back reads from different ports.
      drv0(1'b1, 32'h4, 32'hA);
      next_cyc();
      drv0(1'b1, 32'h8, 32'hB);
      next_cyc();
      drv0(1'b0, 32'h4, 32'h0);
      smp();
      chk("t5_gnt0", {31'd0, bus.p0_gnt}, 32'd1);
      next_cyc();
      idle();
      drv1(1'b0, 32'h8, 32'h0);
      smp();
      chk("t5_gnt1",  {31'd0, bus.p1_gnt},    32'd1);
      chk("t5_rv0",   {31'd0, bus.p0_rvalid}, 32'd1);
      chk("t5_data0", bus.p0_rdata, 32'hA);
      chk("t5_rv1a",  {31'd0, bus.p1_rvalid}, 32'd0);
      next_cyc();
      idle();
      smp();
      chk("t5_rv1",   {31'd0, bus.p1_rvalid}, 32'd1);
      chk("t5_data1", bus.p1_rdata, 32'hB);
      chk("t5_rv0b",  {31'd0, bus.p0_rvalid}, 32'd0);
      next_cyc();

      // Reset lands while a read is in flight.
      drv0(1'b0, 32'h10, 32'h0);
      smp();
      chk("t6_gnt0", {31'd0, bus.p0_gnt}, 32'd1);
      #2;
      reset = 1'b1;
      smp();
      chk("t6_rv0",   {31'd0, bus.p0_rvalid}, 32'd0);
      chk("t6_data0", bus.p0_rdata, 32'd0);
      chk("t6_gnt0r", {31'd0, bus.p0_gnt},  32'd0);
      chk("t6_ren",   {31'd0, bus.mem_ren}, 32'd0);
      next_cyc();
      idle();
      reset = 1'b0;
      next_cyc();
      drv0(1'b0, 32'h10, 32'h0);
      next_cyc();
      idle();
      smp();
      chk("t6_after_rv",   {31'd0, bus.p0_rvalid}, 32'd1);
      chk("t6_after_data", bus.p0_rdata, 32'd0);
      next_cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
